// File: rtl/pipelined_fp_multiplier_if.sv
// Operand/result handshake bundle for pipelined_fp_multiplier.
// master drives operands and out_ready; slave is the multiplier.
interface pipelined_fp_multiplier_if #(
   parameter int MW = 11,
   parameter int EW = 5
);
   logic          in_valid;
   logic          in_ready;
   logic          sx;
   logic          sy;
   logic [MW-1:0] gx;
   logic [MW-1:0] gy;
   logic [EW-1:0] ex;
   logic [EW-1:0] ey;
   logic            out_valid;
   logic            out_ready;
   logic            sign_out;
   logic [EW-1:0]   exp_out;
   logic [MW-1:0]   mant_out;
   logic [2*MW-1:0] product_out;
   logic            ovf;
   logic            unf;

   modport master (
      output in_valid, sx, sy, gx, gy, ex, ey, out_ready,
      input  in_ready, out_valid, sign_out, exp_out,
      input  mant_out, product_out, ovf, unf
   );

   modport slave (
      input  in_valid, sx, sy, gx, gy, ex, ey, out_ready,
      output in_ready, out_valid, sign_out, exp_out,
      output mant_out, product_out, ovf, unf
   );
endinterface

// File: rtl/pipelined_fp_multiplier.sv
// Pipelined sign/exponent/significand multiplier, whole-pipe stall.
// Define ROUND_NEAREST_EN for round-to-nearest-even instead of truncation.
module pipelined_fp_multiplier #(
   parameter int MW   = 11,
   parameter int EW   = 5,
   parameter int BIAS = 2**(EW-1)-1
) (
   input logic clk_in,
   input logic rst_in,
   pipelined_fp_multiplier_if.slave bus
);
   localparam int PW = 2*MW;
   localparam int XW = EW+2;
   localparam logic signed [XW-1:0] EMAX = XW'((2**EW)-1);
   localparam logic signed [XW-1:0] EZRO = '0;

   logic adv;

   logic          v1_q, sx1_q, sy1_q;
   logic [MW-1:0] gx1_q, gy1_q;
   logic [EW-1:0] ex1_q, ey1_q;

   logic                 v2_q, sg2_q, z2_q;
   logic [PW-1:0]        p2_q;
   logic signed [XW-1:0] e2_q;

   logic                 v3_q, sg3_q, z3_q;
   logic [PW-1:0]        p3_q;
   logic [MW-1:0]        m3_q;
   logic signed [XW-1:0] e3_q;

   logic          v4_q, sg4_q, ovf4_q, unf4_q;
   logic [PW-1:0] p4_q;
   logic [MW-1:0] m4_q;
   logic [EW-1:0] x4_q;

   logic [PW-1:0]        p_d;
   logic signed [XW-1:0] e_d;
   logic                 z_d;

   logic [MW-1:0]        m_t, m_n;
   logic signed [XW-1:0] e_t, e_n;

   logic [EW-1:0] x_c;
   logic [MW-1:0] m_c;
   logic          ovf_c, unf_c;

   assign adv = !v4_q || bus.out_ready;
   assign bus.in_ready = adv;

   assign p_d = PW'(gx1_q) * PW'(gy1_q);
   assign e_d = $signed({2'b00, ex1_q}) + $signed({2'b00, ey1_q})
              - $signed(XW'(BIAS));
   assign z_d = (gx1_q == '0) || (gy1_q == '0);

   always_comb begin
      m_t = p2_q[PW-2 -: MW];
      e_t = e2_q;
      if (p2_q[PW-1]) begin
         m_t = p2_q[PW-1 -: MW];
         e_t = e2_q + XW'(1);
      end
   end

`ifdef ROUND_NEAREST_EN
   logic [MW-1:0] drop;
   logic [MW:0]   m_rnd;
   logic          guard, sticky;

   // Low-product case drops one bit fewer; pad so guard stays at the MSB.
   always_comb begin
      drop   = p2_q[PW-1] ? p2_q[MW-1:0] : {p2_q[MW-2:0], 1'b0};
      guard  = drop[MW-1];
      sticky = |drop[MW-2:0];
      m_rnd  = {1'b0, m_t} + (MW+1)'(guard && (sticky || m_t[0]));
      m_n    = m_rnd[MW-1:0];
      e_n    = e_t;
      if (m_rnd[MW]) begin
         m_n = {1'b1, {(MW-1){1'b0}}};
         e_n = e_t + XW'(1);
      end
   end
`else
   assign m_n = m_t;
   assign e_n = e_t;
`endif

   always_comb begin
      x_c   = '0;
      m_c   = '0;
      ovf_c = 1'b0;
      unf_c = 1'b0;
      if (z3_q) begin
         x_c = '0;
      end else if (e3_q >= EMAX) begin
         x_c   = '1;
         ovf_c = 1'b1;
      end else if (e3_q <= EZRO) begin
         unf_c = 1'b1;
      end else begin
         x_c = e3_q[EW-1:0];
         m_c = m3_q;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         v1_q   <= 1'b0;
         sx1_q  <= 1'b0;
         sy1_q  <= 1'b0;
         gx1_q  <= '0;
         gy1_q  <= '0;
         ex1_q  <= '0;
         ey1_q  <= '0;
         v2_q   <= 1'b0;
         sg2_q  <= 1'b0;
         z2_q   <= 1'b0;
         p2_q   <= '0;
         e2_q   <= '0;
         v3_q   <= 1'b0;
         sg3_q  <= 1'b0;
         z3_q   <= 1'b0;
         p3_q   <= '0;
         m3_q   <= '0;
         e3_q   <= '0;
         v4_q   <= 1'b0;
         sg4_q  <= 1'b0;
         ovf4_q <= 1'b0;
         unf4_q <= 1'b0;
         p4_q   <= '0;
         m4_q   <= '0;
         x4_q   <= '0;
      end else if (adv) begin
         v1_q   <= bus.in_valid;
         sx1_q  <= bus.sx;
         sy1_q  <= bus.sy;
         gx1_q  <= bus.gx;
         gy1_q  <= bus.gy;
         ex1_q  <= bus.ex;
         ey1_q  <= bus.ey;
         v2_q   <= v1_q;
         sg2_q  <= sx1_q ^ sy1_q;
         z2_q   <= z_d;
         p2_q   <= p_d;
         e2_q   <= e_d;
         v3_q   <= v2_q;
         sg3_q  <= sg2_q;
         z3_q   <= z2_q;
         p3_q   <= p2_q;
         m3_q   <= m_n;
         e3_q   <= e_n;
         v4_q   <= v3_q;
         sg4_q  <= sg3_q;
         ovf4_q <= ovf_c;
         unf4_q <= unf_c;
         p4_q   <= p3_q;
         m4_q   <= m_c;
         x4_q   <= x_c;
      end
   end

   assign bus.out_valid   = v4_q;
   assign bus.sign_out    = sg4_q;
   assign bus.exp_out     = x4_q;
   assign bus.mant_out    = m4_q;
   assign bus.product_out = p4_q;
   assign bus.ovf         = ovf4_q & v4_q;
   assign bus.unf         = unf4_q & v4_q;
endmodule
